// File: rtl/speed_key_input_if.sv
// Command-pulse interface between the push-button front-end and the speed controller.
// The slave side owns the raw active-low keys as inputs and drives the command pulses.
interface speed_key_input_if;
  logic key_up_n;
  logic key_down_n;
  logic key_rst_n;
  logic up;
  logic down;
  logic speed_rst;
  logic repeating;

  modport master (
    output key_up_n,
    output key_down_n,
    output key_rst_n,
    input  up,
    input  down,
    input  speed_rst,
    input  repeating
  );

  modport slave (
    input  key_up_n,
    input  key_down_n,
    input  key_rst_n,
    output up,
    output down,
    output speed_rst,
    output repeating
  );
endinterface

// File: rtl/speed_key_input.sv
// Push-button front-end: synchronise, debounce and turn three active-low keys into
// single-cycle up/down/speed_rst command pulses, with auto-repeat on held up/down.
module speed_key_input #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic             clk50M,
  input  logic             rst,
  speed_key_input_if.slave kif
);

  localparam int K_UP = 0;
  localparam int K_DN = 1;
  localparam int K_RS = 2;

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_LOCKOUT
  } state_t;

  logic [2:0]      w_key_raw_n;
  logic [2:0]      r_sync1_n;
  logic [2:0]      r_sync2_n;
  logic [2:0]      w_key;
  logic [2:0]      r_stable;
  logic [2:0]      r_stable_d;
  logic [2:0]      w_rise;
  logic [DB_W-1:0] r_db_cnt [3];

  state_t          r_state;
  logic            r_dir;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic            r_up;
  logic            r_down;
  logic            r_speed_rst;
  logic            r_repeating;
  logic            w_held;

  assign w_key_raw_n = {kif.key_rst_n, kif.key_down_n, kif.key_up_n};
  assign w_key       = ~r_sync2_n;
  assign w_rise      = r_stable & ~r_stable_d;
  assign w_held      = r_dir ? r_stable[K_DN] : r_stable[K_UP];

  // Synchronisers reset to the released (high) level so no false press follows reset.
  always_ff @(posedge clk50M) begin
    // NOTE: every clocked block uses non-blocking assignments so all flops update
    // from pre-edge values; blocking here would collapse the two synchroniser stages.
    if (rst) begin
      r_sync1_n <= '1;
      r_sync2_n <= '1;
    end else begin
      r_sync1_n <= w_key_raw_n;
      r_sync2_n <= r_sync1_n;
    end
  end

  // A key change is accepted only after the counter has run to DEBOUNCE_CYCLES
  // without the synchronised level falling back to the accepted one.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < 3; i++) begin
        if (w_key[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= w_key[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Up/down repeat FSM; speed_rst and up+down conflicts pre-empt everything.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_rpt_cnt   <= '0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_speed_rst <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_speed_rst <= w_rise[K_RS];
      if (w_rise[K_RS] || (r_stable[K_UP] && r_stable[K_DN])) begin
        r_state     <= S_LOCKOUT;
        r_rpt_cnt   <= '0;
        r_repeating <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rise[K_UP]) begin
              r_state   <= S_DELAY;
              r_dir     <= 1'b0;
              r_up      <= 1'b1;
              r_rpt_cnt <= DELAY_LOAD;
            end else if (w_rise[K_DN]) begin
              r_state   <= S_DELAY;
              r_dir     <= 1'b1;
              r_down    <= 1'b1;
              r_rpt_cnt <= DELAY_LOAD;
            end
          end
          S_DELAY, S_REPEAT: begin
            // Release beats a same-cycle expiry: no pulse once the key is let go.
            if (!w_held) begin
              r_state     <= S_IDLE;
              r_rpt_cnt   <= '0;
              r_repeating <= 1'b0;
            end else if (r_rpt_cnt == '0) begin
              r_state     <= S_REPEAT;
              r_repeating <= 1'b1;
              r_rpt_cnt   <= PERIOD_LOAD;
              if (r_dir) begin
                r_down <= 1'b1;
              end else begin
                r_up <= 1'b1;
              end
            end else begin
              r_rpt_cnt <= r_rpt_cnt - RPT_W'(1);
            end
          end
          S_LOCKOUT: begin
            if (r_stable == 3'b000) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign kif.up        = r_up;
  assign kif.down      = r_down;
  assign kif.speed_rst = r_speed_rst;
  assign kif.repeating = r_repeating;

endmodule

// File: tb/tb_speed_key_input.sv
// Directed bench for speed_key_input with small debounce/repeat parameters:
// cycle-by-cycle comparison of every output against hand-derived pulse schedules.
module tb_speed_key_input;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int NV = 7;

  logic clk50M = 1'b0;
  logic rst;

  speed_key_input_if kif ();

  speed_key_input #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk50M (clk50M),
    .rst    (rst),
    .kif    (kif)
  );

  always #5 clk50M = ~clk50M;

  // Key intervals are [lo,hi) in cycles where the key is held low; -1 means unused.
  typedef struct {
    int ncyc;
    int up_lo[2];
    int up_hi[2];
    int dn_lo;
    int dn_hi;
    int dn_bnc;
    int rs_lo;
    int rs_hi;
    int rst_at;
    int up_p[6];
    int dn_p[6];
    int rs_p[6];
    int rep_lo[2];
    int rep_hi[2];
  } vec_t;

  vec_t tbl [NV];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int cyc, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic logic in_iv(input int k, input int lo, input int hi);
    return (lo >= 0) && (k >= lo) && (k < hi);
  endfunction

  function automatic logic in_list(input int k, input int l[6]);
    for (int i = 0; i < 6; i++) begin
      if (l[i] == k) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic step(input logic up_n, input logic dn_n, input logic rs_n, input logic r);
    kif.key_up_n   = up_n;
    kif.key_down_n = dn_n;
    kif.key_rst_n  = rs_n;
    rst            = r;
    @(posedge clk50M);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("rst.up", i, kif.up, 1'b0);
      check("rst.down", i, kif.down, 1'b0);
      check("rst.speed_rst", i, kif.speed_rst, 1'b0);
      check("rst.repeating", i, kif.repeating, 1'b0);
    end
    rst = 1'b0;
  endtask

  task automatic run_vec(input int s, input vec_t v);
    logic up_n, dn_n, rs_n, r;
    for (int k = 0; k < v.ncyc; k++) begin
      up_n = !(in_iv(k, v.up_lo[0], v.up_hi[0]) || in_iv(k, v.up_lo[1], v.up_hi[1]));
      dn_n = !(in_iv(k, v.dn_lo, v.dn_hi) || ((k < v.dn_bnc) && ((k % 4) < 2)));
      rs_n = !in_iv(k, v.rs_lo, v.rs_hi);
      r    = (k == v.rst_at);
      step(up_n, dn_n, rs_n, r);
      check($sformatf("v%0d.up", s), k, kif.up, in_list(k, v.up_p));
      check($sformatf("v%0d.down", s), k, kif.down, in_list(k, v.dn_p));
      check($sformatf("v%0d.speed_rst", s), k, kif.speed_rst, in_list(k, v.rs_p));
      check($sformatf("v%0d.repeating", s), k, kif.repeating,
            in_iv(k, v.rep_lo[0], v.rep_hi[0]) || in_iv(k, v.rep_lo[1], v.rep_hi[1]));
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    kif.key_up_n   = 1'b1;
    kif.key_down_n = 1'b1;
    kif.key_rst_n  = 1'b1;

    // Basic up press: pulse at DB+3 = 7 only.
    tbl[0] = '{30, '{0, -1}, '{10, -1}, -1, -1, 0, -1, -1, -1,
               '{7, -1, -1, -1, -1, -1}, '{default: -1}, '{default: -1},
               '{-1, -1}, '{-1, -1}};
    // Basic down press.
    tbl[1] = '{30, '{-1, -1}, '{-1, -1}, 0, 10, 0, -1, -1, -1,
               '{default: -1}, '{7, -1, -1, -1, -1, -1}, '{default: -1},
               '{-1, -1}, '{-1, -1}};
    // Down bouncing every 2 cycles until 20, then held: one pulse at 27.
    tbl[2] = '{50, '{-1, -1}, '{-1, -1}, 20, 36, 20, -1, -1, -1,
               '{default: -1}, '{27, -1, -1, -1, -1, -1}, '{default: -1},
               '{-1, -1}, '{-1, -1}};
    // Up held 60 cycles: auto-repeat; release debounced into IDLE at 67.
    tbl[3] = '{80, '{0, -1}, '{60, -1}, -1, -1, 0, -1, -1, -1,
               '{7, 27, 35, 43, 51, 59}, '{default: -1}, '{default: -1},
               '{27, -1}, '{67, -1}};
    // Conflict: lockout at 19, IDLE at 39, fresh up press at 40 pulses at 47.
    tbl[4] = '{65, '{0, 40}, '{30, 50}, 12, 32, 0, -1, -1, -1,
               '{7, 47, -1, -1, -1, -1}, '{default: -1}, '{default: -1},
               '{-1, -1}, '{-1, -1}};
    // Reset key and up together: speed_rst wins, up never fires.
    tbl[5] = '{30, '{0, -1}, '{15, -1}, -1, -1, 0, 0, 15, -1,
               '{default: -1}, '{default: -1}, '{7, -1, -1, -1, -1, -1},
               '{-1, -1}, '{-1, -1}};
    // Sync reset at 30 mid-repeat: re-press pulses at 38, repeat resumes at 58.
    tbl[6] = '{75, '{0, -1}, '{62, -1}, -1, -1, 0, -1, -1, 30,
               '{7, 27, 38, 58, 66, -1}, '{default: -1}, '{default: -1},
               '{27, 58}, '{30, 69}};

    do_reset(3);
    for (int s = 0; s < NV; s++) begin
      run_vec(s, tbl[s]);
      do_reset(2);
    end

    // Short glitches on down (1 cycle) and reset key (3 cycles) must be ignored.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, !(k == 3), !((k >= 5) && (k < 8)), 1'b0);
      check("glitch.down", k, kif.down, 1'b0);
      check("glitch.speed_rst", k, kif.speed_rst, 1'b0);
      check("glitch.up", k, kif.up, 1'b0);
    end

    // Reset key held long: exactly one speed_rst, never repeats.
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("hold_rs.speed_rst", k, kif.speed_rst, k == 7);
      check("hold_rs.up", k, kif.up, 1'b0);
      check("hold_rs.repeating", k, kif.repeating, 1'b0);
    end
    do_reset(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
